mem_arb: RTL and testbench

Round-robin arbiter that shares the single 8-bit spram port among up to N bus masters of the outer interpreter (finder, atoier, eforth, comma). It replaces per-state hand muxing of master buses with registered one-hot grants, optional burst locking, read-data-valid tracking and a bounded hold timer. It sits between the master-side bus ports and the spram slave.

---
 rtl/forthsuper_pkg.sv | 18 +
 rtl/rr_pick.sv | 33 +++
 rtl/mem_arb.sv | 146 ++++++++++++++
 tb/tb_mem_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forthsuper_pkg.sv
// Shared types and defaults for the outer-interpreter memory path.
package forthsuper_pkg;

    // Arbiter state: nobody owns the spram port, or one master owns it.
    typedef enum logic {
        A_IDLE = 1'b0,
        A_OWN  = 1'b1
    } arb_sts;

    // Default number of bus masters (finder, atoier, eforth, comma).
    localparam int MB_N = 4;

    // Width of an index into n requesters; never zero.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, ptr itself last.
module rr_pick
    import forthsuper_pkg::*;
#(
    parameter int N  = MB_N,
    parameter int OW = idx_w(MB_N)
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] ptr,
    output logic [OW-1:0] idx,
    output logic          any
);

    int unsigned   cand;
    logic [OW-1:0] cand_idx;

    // Scan ptr+1, ptr+2, ... wrapping mod N; the first requester found wins.
    always_comb begin
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(ptr) + k) % N;
            cand_idx = OW'(cand);
            if (!any && req[cand_idx]) begin
                idx = cand_idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing the single spram port among N bus masters.
// Handshake: a master owns the port in every cycle where gnt[i] is high; an
// access happens only in cycles with gnt[i] && req[i]. Read data for such a
// cycle is presented on vo one cycle later, qualified by vld[i].
module mem_arb
    import forthsuper_pkg::*;
#(
    parameter int N    = MB_N,
    parameter int ASZ  = 17,
    parameter int MSZ  = 8,
    parameter int MAXH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    input  logic [N-1:0]     we,
    input  logic [N*ASZ-1:0] ai,
    input  logic [N*MSZ-1:0] vi,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     vld,
    output logic [MSZ-1:0]   vo,
    output logic             m_we,
    output logic [ASZ-1:0]   m_ai,
    output logic [MSZ-1:0]   m_vi,
    input  logic [MSZ-1:0]   m_vo,
    output logic             tmo,
    output arb_sts           sts
);

    localparam int OW = idx_w(N);
    localparam int HW = (MAXH < 1) ? 1 : $clog2(MAXH + 1);

    arb_sts        state, nxt_state;
    logic [OW-1:0] own, nxt_own;
    logic [OW-1:0] ptr, nxt_ptr;
    logic [HW-1:0] hcnt, nxt_hcnt;
    logic          tmo_q;
    logic [N-1:0]  vld_q;
    logic [N-1:0]  gnt_q;

    logic [N-1:0]  own_oh;
    logic [N-1:0]  others;
    logic          owned;
    logic          other_pend;
    logic          acc;
    logic          force_rot;
    logic [N-1:0]  pick_req;
    logic [OW-1:0] pick_ptr;
    logic [OW-1:0] pick_idx;
    logic          pick_any;

    assign own_oh     = N'(1) << own;
    assign owned      = (state == A_OWN);
    assign others     = req & ~own_oh;
    assign other_pend = owned && (|others);
    assign acc        = owned && req[own];
    assign force_rot  = (MAXH != 0) && (32'(hcnt) == 32'(MAXH - 1));

    // While owned, the current owner is the rotation point and is masked out;
    // when idle, the last owner is the rotation point.
    assign pick_req = owned ? others : req;
    assign pick_ptr = owned ? own : ptr;

    rr_pick #(
        .N  (N),
        .OW (OW)
    ) u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next owner, rotation pointer and hold count.
    always_comb begin
        nxt_state = state;
        nxt_own   = own;
        nxt_ptr   = ptr;
        nxt_hcnt  = '0;
        case (state)
            A_IDLE: begin
                if (pick_any) begin
                    nxt_state = A_OWN;
                    nxt_own   = pick_idx;
                end
            end
            A_OWN: begin
                if ((req[own] && lock[own] && !force_rot) || (req[own] && !other_pend)) begin
                    if (other_pend) begin
                        nxt_hcnt = (hcnt == HW'(MAXH)) ? hcnt : hcnt + HW'(1);
                    end
                end else if (other_pend) begin
                    nxt_own = pick_idx;
                    nxt_ptr = own;
                end else begin
                    nxt_state = A_IDLE;
                    nxt_ptr   = own;
                end
            end
            default: begin
                nxt_state = A_IDLE;
            end
        endcase
    end

    // Arbiter registers; reset leaves ptr at N-1 so master 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= A_IDLE;
            own   <= '0;
            ptr   <= OW'(N - 1);
            hcnt  <= '0;
            gnt_q <= '0;
            vld_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            state <= nxt_state;
            own   <= nxt_own;
            ptr   <= nxt_ptr;
            hcnt  <= nxt_hcnt;
            gnt_q <= (nxt_state == A_OWN) ? (N'(1) << nxt_own) : '0;
            vld_q <= (acc && !we[own]) ? own_oh : '0;
            tmo_q <= tmo_q | (force_rot && other_pend);
        end
    end

    // Memory bus mux: the owner drives the port only in an access cycle.
    always_comb begin
        m_we = 1'b0;
        m_ai = '0;
        m_vi = '0;
        if (acc) begin
            m_we = we[own];
            m_ai = ai[own*ASZ +: ASZ];
            m_vi = vi[own*MSZ +: MSZ];
        end
    end

    assign gnt = gnt_q;
    assign vld = vld_q;
    assign vo  = m_vo;
    assign tmo = tmo_q;
    assign sts = state;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: behavioural arbiter + memory model feeding a scoreboard.
module tb_mem_arb;
    import forthsuper_pkg::*;

    localparam int N    = 4;
    localparam int ASZ  = 17;
    localparam int MSZ  = 8;
    localparam int MAXH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]     req, lock, we;
    logic [N*ASZ-1:0] ai;
    logic [N*MSZ-1:0] vi;
    logic [N-1:0]     gnt, vld;
    logic [MSZ-1:0]   vo;
    logic             m_we;
    logic [ASZ-1:0]   m_ai;
    logic [MSZ-1:0]   m_vi;
    logic [MSZ-1:0]   m_vo;
    logic             tmo;
    arb_sts           sts;

    mem_arb #(.N(N), .ASZ(ASZ), .MSZ(MSZ), .MAXH(MAXH)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .lock (lock),
        .we   (we),
        .ai   (ai),
        .vi   (vi),
        .gnt  (gnt),
        .vld  (vld),
        .vo   (vo),
        .m_we (m_we),
        .m_ai (m_ai),
        .m_vi (m_vi),
        .m_vo (m_vo),
        .tmo  (tmo),
        .sts  (sts)
    );

    // spram slave seen by the DUT, one-cycle read latency
    logic [MSZ-1:0] spram   [0:(1<<ASZ)-1];
    logic [MSZ-1:0] ref_mem [0:(1<<ASZ)-1];

    always @(posedge clk) begin
        if (m_we) spram[m_ai] <= m_vi;
        m_vo <= spram[m_ai];
    end

    function automatic logic [MSZ-1:0] init_val(input int a);
        return MSZ'((a * 37) ^ 8'h5A);
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [N-1:0]   gnt;
        logic           we;
        logic [ASZ-1:0] ai;
        logic [MSZ-1:0] vi;
        logic [N-1:0]   vld;
        logic           tmo;
    } exp_t;

    logic [$bits(exp_t)-1:0] exp_q[$];
    logic [MSZ-1:0]          rd_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner -1 means nobody holds the port; last is the previous owner.
    int           mo_owner;
    int           mo_last;
    int           mo_hcnt;
    logic         mo_tmo;
    logic [N-1:0] mo_vld;

    task automatic model_reset();
        mo_owner = -1;
        mo_last  = N - 1;
        mo_hcnt  = 0;
        mo_tmo   = 1'b0;
        mo_vld   = '0;
    endtask

    function automatic int rr_next(input int from, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    // Predict this cycle's outputs from the current inputs, then advance.
    task automatic model_step();
        exp_t           e;
        int             o;
        logic           acc;
        logic           force_now;
        logic [N-1:0]   others;
        logic [ASZ-1:0] a;
        o   = mo_owner;
        acc = (o >= 0) && req[o];
        e.gnt = (o >= 0) ? (N'(1) << o) : '0;
        e.we  = acc ? we[o] : 1'b0;
        a     = acc ? ai[o*ASZ +: ASZ] : '0;
        e.ai  = a;
        e.vi  = acc ? vi[o*MSZ +: MSZ] : '0;
        e.vld = mo_vld;
        e.tmo = mo_tmo;
        exp_q.push_back(e);

        mo_vld = '0;
        if (acc) begin
            if (we[o]) begin
                ref_mem[a] = e.vi;
            end else begin
                rd_q.push_back(ref_mem[a]);
                mo_vld = N'(1) << o;
            end
        end

        if (o < 0) begin
            if (req != '0) mo_owner = rr_next(mo_last, req);
            mo_hcnt = 0;
        end else begin
            others    = req;
            others[o] = 1'b0;
            force_now = (MAXH != 0) && (mo_hcnt == MAXH - 1);
            if (others != '0 && force_now) mo_tmo = 1'b1;
            if (req[o] && ((lock[o] && !force_now) || others == '0)) begin
                if (others != '0) mo_hcnt = (mo_hcnt < MAXH) ? mo_hcnt + 1 : MAXH;
                else              mo_hcnt = 0;
            end else begin
                mo_last  = o;
                mo_owner = (others != '0) ? rr_next(o, others) : -1;
                mo_hcnt  = 0;
            end
        end
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_t'(exp_q.pop_front());
                check("gnt",  32'(gnt),  32'(mon_e.gnt));
                check("m_we", 32'(m_we), 32'(mon_e.we));
                check("m_ai", 32'(m_ai), 32'(mon_e.ai));
                check("m_vi", 32'(m_vi), 32'(mon_e.vi));
                check("vld",  32'(vld),  32'(mon_e.vld));
                check("tmo",  32'(tmo),  32'(mon_e.tmo));
                if (vld != '0) begin
                    if (rd_q.size() == 0) check("vo_unexpected", 32'(vld), 32'(0));
                    else                  check("vo", 32'(vo), 32'(rd_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ai(input int i, input logic [ASZ-1:0] a);
        ai[i*ASZ +: ASZ] = a;
    endtask

    task automatic set_vi(input int i, input logic [MSZ-1:0] v);
        vi[i*MSZ +: MSZ] = v;
    endtask

    // Drive one cycle's inputs (called just after a rising edge).
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] w);
        req  = r;
        lock = l;
        we   = w;
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] r, l, w;
        req = '0; lock = '0; we = '0; ai = '0; vi = '0;
        for (int a = 0; a < (1 << ASZ); a++) begin
            spram[a]   = init_val(a);
            ref_mem[a] = init_val(a);
        end
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",  32'(gnt),  32'(0));
        check("rst_vld",  32'(vld),  32'(0));
        check("rst_m_we", 32'(m_we), 32'(0));
        check("rst_m_ai", 32'(m_ai), 32'(0));
        check("rst_m_vi", 32'(m_vi), 32'(0));
        check("rst_tmo",  32'(tmo),  32'(0));
        check("rst_sts",  32'(sts),  32'(A_IDLE));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single read by master 0 of 0x0010
        set_ai(0, 17'h00010);
        step(4'b0001, 4'b0000, 4'b0000);
        check("t1_gnt",  32'(gnt),  32'(4'b0001));
        check("t1_m_ai", 32'(m_ai), 32'(17'h00010));
        step(4'b0001, 4'b0000, 4'b0000);
        check("t1_vld", 32'(vld), 32'(4'b0001));
        check("t1_vo",  32'(vo),  32'(init_val(32'h10)));
        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);

        // all masters requesting, unlocked
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_ai(i, ASZ'($urandom_range(0, 31)));
            step(4'b1111, 4'b0000, 4'b0000);
        end
        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);

        // master 2 locked, master 1 arrives, lock released
        for (int c = 0; c < 5; c++) step(4'b0100, 4'b0100, 4'b0000);
        step(4'b0110, 4'b0100, 4'b0000);
        step(4'b0110, 4'b0100, 4'b0000);
        check("t3_gnt_locked", 32'(gnt), 32'(4'b0100));
        step(4'b0110, 4'b0000, 4'b0000);
        check("t3_gnt_handoff", 32'(gnt), 32'(4'b0010));
        step(4'b0010, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);

        // hold limit: master 0 locked, master 3 waiting
        step(4'b0001, 4'b0001, 4'b0000);
        for (int c = 0; c < MAXH; c++) begin
            check("t4_gnt_hold", 32'(gnt), 32'(4'b0001));
            step(4'b1001, 4'b0001, 4'b0000);
        end
        check("t4_gnt_forced", 32'(gnt), 32'(4'b1000));
        check("t4_tmo_set",    32'(tmo), 32'(1));
        step(4'b1001, 4'b0001, 4'b0000);
        step(4'b1001, 4'b0001, 4'b0000);
        for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 4'b0000);
        check("t4_tmo_sticky", 32'(tmo), 32'(1));

        // write 0xA5 to 0x0100 by master 1, read it back by master 3
        set_ai(1, 17'h00100);
        set_vi(1, 8'hA5);
        step(4'b0010, 4'b0000, 4'b0010);
        step(4'b0010, 4'b0000, 4'b0010);
        step(4'b0000, 4'b0000, 4'b0000);
        set_ai(3, 17'h00100);
        step(4'b1000, 4'b0000, 4'b0000);
        step(4'b1000, 4'b0000, 4'b0000);
        check("t5_vld", 32'(vld), 32'(4'b1000));
        check("t5_vo",  32'(vo),  32'(8'hA5));
        step(4'b0000, 4'b0000, 4'b0000);

        // randomized traffic, patterns held for a few cycles
        for (int it = 0; it < 120; it++) begin
            r = N'($urandom_range(0, 15));
            l = N'($urandom_range(0, 15)) & (($urandom_range(0, 2) == 0) ? 4'hF : 4'h0);
            w = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                set_ai(i, ASZ'($urandom_range(0, 31)));
                set_vi(i, MSZ'($urandom_range(0, 255)));
            end
            repeat ($urandom_range(1, 3)) step(r, l, w);
        end
        for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 4'b0000);

        // asynchronous reset in the middle of a granted write
        set_ai(0, 17'h1FFFF);
        set_vi(0, 8'h3C);
        step(4'b0001, 4'b0000, 4'b0001);
        check("t7_gnt_before",  32'(gnt),  32'(4'b0001));
        check("t7_m_we_before", 32'(m_we), 32'(1));
        rst = 1'b0;
        #1;
        check("t7_gnt_async",  32'(gnt),  32'(0));
        check("t7_vld_async",  32'(vld),  32'(0));
        check("t7_m_we_async", 32'(m_we), 32'(0));
        check("t7_tmo_async",  32'(tmo),  32'(0));
        exp_q.delete();
        rd_q.delete();
        model_reset();
        req = '0; lock = '0; we = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        set_ai(1, 17'h00005);
        set_ai(3, 17'h00006);
        step(4'b1010, 4'b0000, 4'b0000);
        check("t7_first_winner", 32'(gnt), 32'(4'b0010));
        for (int c = 0; c < 3; c++) step(4'b1010, 4'b0000, 4'b0000);
        for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 4'b0000);

        // ---------------- report ----------------
        check("exp_q_drained", 32'(exp_q.size()), 32'(0));
        check("rd_q_drained",  32'(rd_q.size()),  32'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
